vc_wrr_arbiter: RTL

Weighted round-robin pop arbiter between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1) of the QoS datapath. It runs only while the QoS control FSM reports active and no FIFO error is flagged. It pops one word per cycle from the granted VC, steers it by its destination bit, and pushes it into D0 or D1. Backpressure comes from the destination almost-full flags.

---
 rtl/vc_wrr_arbiter_pkg.sv | 34 +++
 rtl/vc_wrr_arbiter_pop_push_pipe.sv | 71 +++++++
 rtl/vc_wrr_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/vc_wrr_arbiter_pkg.sv
// Shared definitions for the QoS weighted round-robin pop arbiter:
// FSM state encodings, default word geometry, weight field layout and
// the effective-weight helper.
package vc_wrr_arbiter_pkg;

  // Default word geometry of the VC and destination FIFOs
  localparam int ARB_DATA_W   = 32'd6;
  localparam int ARB_DEST_BIT = 32'd4;

  // Error / weight / counter widths; the QoS FSM uses the same error width
  localparam int ERR_W       = 32'd5;
  localparam int WGT_W       = 32'd4;
  localparam int WGT_VC0_LSB = 32'd0;
  localparam int WGT_VC1_LSB = 32'd4;
  localparam int CNT_W       = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_VC0  = 2'b01,
    ST_VC1  = 2'b10
  } arb_state_e;

  // A programmed weight of zero still grants one pop per turn
  function automatic logic [CNT_W-1:0] eff_weight(input logic [WGT_W-1:0] w);
    logic [CNT_W-1:0] r;
    if (w == 4'd0) begin
      r = 4'd1;
    end else begin
      r = w;
    end
    return r;
  endfunction

endpackage

// File: rtl/vc_wrr_arbiter_pop_push_pipe.sv
// Two-stage source-select / destination-steer pipeline.
// Stage 1 remembers which VC was popped; the VC read data is valid during
// stage 1, so stage 2 captures it and raises the push strobe chosen by the
// destination bit. A pop in cycle n yields a push in cycle n+2.
module vc_wrr_arbiter_pop_push_pipe
  import vc_wrr_arbiter_pkg::*;
#(
  parameter int DATA_W   = ARB_DATA_W,
  parameter int DEST_BIT = ARB_DEST_BIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vc0_pop,
  input  logic              vc1_pop,
  input  logic [DATA_W-1:0] vc0_data,
  input  logic [DATA_W-1:0] vc1_data,
  output logic              s1_valid,
  output logic [DATA_W-1:0] d_data,
  output logic              d0_push,
  output logic              d1_push
);

  logic              s1_valid_r;
  logic              s1_src_r;
  logic [DATA_W-1:0] sel_data_s;
  logic [DATA_W-1:0] d_data_r;
  logic              d0_push_r;
  logic              d1_push_r;

  // Stage 1: record that a pop happened and which VC it came from
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_r <= 1'b0;
      s1_src_r   <= 1'b0;
    end else begin
      s1_valid_r <= vc0_pop | vc1_pop;
      s1_src_r   <= vc1_pop;
    end
  end

  // Select the read data of the VC popped in the previous cycle
  always_comb begin
    sel_data_s = vc0_data;
    if (s1_src_r) begin
      sel_data_s = vc1_data;
    end else begin
      sel_data_s = vc0_data;
    end
  end

  // Stage 2: register the word and steer it by its destination bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_data_r  <= {DATA_W{1'b0}};
      d0_push_r <= 1'b0;
      d1_push_r <= 1'b0;
    end else begin
      d0_push_r <= s1_valid_r & ~sel_data_s[DEST_BIT];
      d1_push_r <= s1_valid_r &  sel_data_s[DEST_BIT];
      if (s1_valid_r) begin
        d_data_r <= sel_data_s;
      end
    end
  end

  assign s1_valid = s1_valid_r;
  assign d_data   = d_data_r;
  assign d0_push  = d0_push_r;
  assign d1_push  = d1_push_r;

endmodule

// File: rtl/vc_wrr_arbiter.sv
// Weighted round-robin pop arbiter between VC0/VC1 and destinations D0/D1.
// Holds the grant FSM, the per-turn grant counter and the pop strobes; the
// data path lives in the pop/push pipeline. Pops are combinational from the
// state so that turn switches cost no bubble; backpressure is taken from
// both almost-full flags because the destination is unknown before the pop.
module vc_wrr_arbiter
  import vc_wrr_arbiter_pkg::*;
#(
  parameter int DATA_W   = ARB_DATA_W,
  parameter int DEST_BIT = ARB_DEST_BIT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               active_in,
  input  logic [ERR_W-1:0]   error_in,
  input  logic [2*WGT_W-1:0] weights,
  input  logic               vc0_empty,
  input  logic               vc1_empty,
  input  logic [DATA_W-1:0]  vc0_data,
  input  logic [DATA_W-1:0]  vc1_data,
  input  logic               d0_almost_full,
  input  logic               d1_almost_full,
  output logic               vc0_pop,
  output logic               vc1_pop,
  output logic [DATA_W-1:0]  d_data,
  output logic               d0_push,
  output logic               d1_push,
  output logic               arb_idle
);

  arb_state_e       state_r;
  arb_state_e       state_n_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_n_s;
  logic             enable_s;
  logic             bp_s;
  logic [CNT_W-1:0] w0_s;
  logic [CNT_W-1:0] w1_s;
  logic             vc0_pop_s;
  logic             vc1_pop_s;
  logic             s1_valid_s;
  logic             arb_idle_r;

  assign enable_s = active_in & ~(|error_in);
  assign bp_s     = d0_almost_full | d1_almost_full;
  // Weights are sampled live; a change lands at the next turn-end compare
  assign w0_s     = eff_weight(weights[WGT_VC0_LSB +: WGT_W]);
  assign w1_s     = eff_weight(weights[WGT_VC1_LSB +: WGT_W]);

  // Grant FSM next state, grant counter and pop strobes
  always_comb begin
    state_n_s = state_r;
    cnt_n_s   = cnt_r;
    vc0_pop_s = 1'b0;
    vc1_pop_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (enable_s && !vc0_empty) begin
          state_n_s = ST_VC0;
          cnt_n_s   = 4'd0;
        end else if (enable_s && !vc1_empty) begin
          state_n_s = ST_VC1;
          cnt_n_s   = 4'd0;
        end else begin
          state_n_s = ST_IDLE;
          cnt_n_s   = 4'd0;
        end
      end
      ST_VC0: begin
        vc0_pop_s = ~vc0_empty & ~bp_s & enable_s;
        if (!enable_s) begin
          state_n_s = ST_IDLE;
          cnt_n_s   = 4'd0;
        end else if (vc0_empty) begin
          cnt_n_s = 4'd0;
          if (!vc1_empty) begin
            state_n_s = ST_VC1;
          end else begin
            state_n_s = ST_IDLE;
          end
        end else if (bp_s) begin
          cnt_n_s = cnt_r;
        end else if ((cnt_r + 4'd1) == w0_s) begin
          // Turn exhausted: hand over, or start a fresh turn if VC1 is dry
          cnt_n_s = 4'd0;
          if (!vc1_empty) begin
            state_n_s = ST_VC1;
          end else begin
            state_n_s = ST_VC0;
          end
        end else begin
          cnt_n_s = cnt_r + 4'd1;
        end
      end
      ST_VC1: begin
        vc1_pop_s = ~vc1_empty & ~bp_s & enable_s;
        if (!enable_s) begin
          state_n_s = ST_IDLE;
          cnt_n_s   = 4'd0;
        end else if (vc1_empty) begin
          cnt_n_s = 4'd0;
          if (!vc0_empty) begin
            state_n_s = ST_VC0;
          end else begin
            state_n_s = ST_IDLE;
          end
        end else if (bp_s) begin
          cnt_n_s = cnt_r;
        end else if ((cnt_r + 4'd1) == w1_s) begin
          cnt_n_s = 4'd0;
          if (!vc0_empty) begin
            state_n_s = ST_VC0;
          end else begin
            state_n_s = ST_VC1;
          end
        end else begin
          cnt_n_s = cnt_r + 4'd1;
        end
      end
      default: begin
        state_n_s = ST_IDLE;
        cnt_n_s   = 4'd0;
      end
    endcase
  end

  // State and grant counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_n_s;
      cnt_r   <= cnt_n_s;
    end
  end

  // Idle flag computed from next-cycle values so it tracks the current
  // state/pipeline exactly: next stage-1 valid is this cycle's pop, next
  // push is this cycle's stage-1 valid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      arb_idle_r <= 1'b1;
    end else begin
      arb_idle_r <= (state_n_s == ST_IDLE) & ~(vc0_pop_s | vc1_pop_s) & ~s1_valid_s;
    end
  end

  vc_wrr_arbiter_pop_push_pipe #(
    .DATA_W   (DATA_W),
    .DEST_BIT (DEST_BIT)
  ) u_pipe (
    .clk      (clk),
    .reset    (reset),
    .vc0_pop  (vc0_pop_s),
    .vc1_pop  (vc1_pop_s),
    .vc0_data (vc0_data),
    .vc1_data (vc1_data),
    .s1_valid (s1_valid_s),
    .d_data   (d_data),
    .d0_push  (d0_push),
    .d1_push  (d1_push)
  );

  assign vc0_pop  = vc0_pop_s;
  assign vc1_pop  = vc1_pop_s;
  assign arb_idle = arb_idle_r;

endmodule
